// File: rtl/axi_remap_pkg.sv
// Shared types and the region-decode helper for the AXI address remapper.
// Decode is done at a fixed maximum width; callers zero-extend and truncate.
package axi_remap_pkg;

    localparam int MAX_AW      = 64;
    localparam int MAX_REGIONS = 16;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_FWD  = 2'd1,
        W_SINK = 2'd2,
        W_RESP = 2'd3
    } wstate_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_ERR  = 1'b1
    } rstate_e;

    typedef struct packed {
        logic              hit;
        logic [3:0]        idx;
        logic [MAX_AW-1:0] addr;
    } decode_t;

    function automatic decode_t region_decode(
        input logic [MAX_AW-1:0]             addr,
        input logic [MAX_REGIONS*MAX_AW-1:0] base,
        input logic [MAX_REGIONS*MAX_AW-1:0] mask,
        input logic [MAX_REGIONS*MAX_AW-1:0] tgt,
        input int                            nregions
    );
        decode_t           res;
        logic [MAX_AW-1:0] m;
        res.hit  = 1'b0;
        res.idx  = '0;
        res.addr = addr;
        // Scanning downward leaves the lowest matching region as the winner.
        for (int i = MAX_REGIONS - 1; i >= 0; i--) begin
            m = mask[i*MAX_AW +: MAX_AW];
            if (i < nregions && (addr & m) == (base[i*MAX_AW +: MAX_AW] & m)) begin
                res.hit  = 1'b1;
                res.idx  = 4'(i);
                res.addr = (addr & ~m) | (tgt[i*MAX_AW +: MAX_AW] & m);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_remap_slice.sv
// One-entry valid/ready register slice; accepts a new word in the same cycle
// the held word drains, so it sustains one transfer per cycle.
module axi_remap_slice #(
    parameter int P_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    input  logic [P_WIDTH-1:0] s_data,
    output logic               s_ready,
    output logic               m_valid,
    output logic [P_WIDTH-1:0] m_data,
    input  logic               m_ready
);

    logic               full_q, full_d;
    logic [P_WIDTH-1:0] data_q, data_d;

    assign s_ready = !full_q || m_ready;
    assign m_valid = full_q;
    assign m_data  = data_q;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (s_valid && s_ready) begin
            full_d = 1'b1;
            data_d = s_data;
        end else if (m_ready) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/axi_remap_regions.sv
// AXI4 address remapper: N-region decode with registered AW/AR slices and a
// local DECERR responder so unmapped bursts never reach the downstream slave.
module axi_remap_regions
    import axi_remap_pkg::*;
#(
    parameter int P_AXI_IDWIDTH = 5,
    parameter int P_ADDRWIDTH   = 32,
    parameter int P_DATAWIDTH   = 64,
    parameter int P_USERWIDTH   = 1,
    parameter int P_NREGIONS    = 4,
    parameter logic [P_NREGIONS*P_ADDRWIDTH-1:0] P_REGION_BASE = '0,
    parameter logic [P_NREGIONS*P_ADDRWIDTH-1:0] P_REGION_MASK = '0,
    parameter logic [P_NREGIONS*P_ADDRWIDTH-1:0] P_REGION_TGT  = '0,
    parameter bit   P_DECERR    = 1'b1,
    parameter int   P_MAXOUT    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    // slave write address
    input  logic [P_ADDRWIDTH-1:0]   axis_awaddr,
    input  logic [7:0]               axis_awlen,
    input  logic [2:0]               axis_awsize,
    input  logic [1:0]               axis_awburst,
    input  logic [P_AXI_IDWIDTH-1:0] axis_awid,
    input  logic                     axis_awlock,
    input  logic [3:0]               axis_awcache,
    input  logic [2:0]               axis_awprot,
    input  logic [P_USERWIDTH-1:0]   axis_awuser,
    input  logic                     axis_awvalid,
    output logic                     axis_awready,
    // slave write data
    input  logic [P_DATAWIDTH-1:0]   axis_wdata,
    input  logic [P_DATAWIDTH/8-1:0] axis_wstrb,
    input  logic                     axis_wlast,
    input  logic [P_USERWIDTH-1:0]   axis_wuser,
    input  logic                     axis_wvalid,
    output logic                     axis_wready,
    // slave write response
    output logic [P_AXI_IDWIDTH-1:0] axis_bid,
    output logic [1:0]               axis_bresp,
    output logic [P_USERWIDTH-1:0]   axis_buser,
    output logic                     axis_bvalid,
    input  logic                     axis_bready,
    // slave read address
    input  logic [P_ADDRWIDTH-1:0]   axis_araddr,
    input  logic [7:0]               axis_arlen,
    input  logic [2:0]               axis_arsize,
    input  logic [1:0]               axis_arburst,
    input  logic [P_AXI_IDWIDTH-1:0] axis_arid,
    input  logic                     axis_arlock,
    input  logic [3:0]               axis_arcache,
    input  logic [2:0]               axis_arprot,
    input  logic [P_USERWIDTH-1:0]   axis_aruser,
    input  logic                     axis_arvalid,
    output logic                     axis_arready,
    // slave read data
    output logic [P_AXI_IDWIDTH-1:0] axis_rid,
    output logic [P_DATAWIDTH-1:0]   axis_rdata,
    output logic [1:0]               axis_rresp,
    output logic                     axis_rlast,
    output logic [P_USERWIDTH-1:0]   axis_ruser,
    output logic                     axis_rvalid,
    input  logic                     axis_rready,
    // master write address
    output logic [P_ADDRWIDTH-1:0]   axim_awaddr,
    output logic [7:0]               axim_awlen,
    output logic [2:0]               axim_awsize,
    output logic [1:0]               axim_awburst,
    output logic [P_AXI_IDWIDTH-1:0] axim_awid,
    output logic                     axim_awlock,
    output logic [3:0]               axim_awcache,
    output logic [2:0]               axim_awprot,
    output logic [P_USERWIDTH-1:0]   axim_awuser,
    output logic                     axim_awvalid,
    input  logic                     axim_awready,
    // master write data
    output logic [P_DATAWIDTH-1:0]   axim_wdata,
    output logic [P_DATAWIDTH/8-1:0] axim_wstrb,
    output logic                     axim_wlast,
    output logic [P_USERWIDTH-1:0]   axim_wuser,
    output logic                     axim_wvalid,
    input  logic                     axim_wready,
    // master write response
    input  logic [P_AXI_IDWIDTH-1:0] axim_bid,
    input  logic [1:0]               axim_bresp,
    input  logic [P_USERWIDTH-1:0]   axim_buser,
    input  logic                     axim_bvalid,
    output logic                     axim_bready,
    // master read address
    output logic [P_ADDRWIDTH-1:0]   axim_araddr,
    output logic [7:0]               axim_arlen,
    output logic [2:0]               axim_arsize,
    output logic [1:0]               axim_arburst,
    output logic [P_AXI_IDWIDTH-1:0] axim_arid,
    output logic                     axim_arlock,
    output logic [3:0]               axim_arcache,
    output logic [2:0]               axim_arprot,
    output logic [P_USERWIDTH-1:0]   axim_aruser,
    output logic                     axim_arvalid,
    input  logic                     axim_arready,
    // master read data
    input  logic [P_AXI_IDWIDTH-1:0] axim_rid,
    input  logic [P_DATAWIDTH-1:0]   axim_rdata,
    input  logic [1:0]               axim_rresp,
    input  logic                     axim_rlast,
    input  logic [P_USERWIDTH-1:0]   axim_ruser,
    input  logic                     axim_rvalid,
    output logic                     axim_rready,
    // state observation
    output wstate_e                  dbg_wst,
    output rstate_e                  dbg_rst
);

    localparam int AX_W = P_ADDRWIDTH + 8 + 3 + 2 + P_AXI_IDWIDTH + 1 + 4 + 3 + P_USERWIDTH;
    localparam int CW   = $clog2(P_MAXOUT + 1);

    logic [MAX_REGIONS*MAX_AW-1:0] base_pad, mask_pad, tgt_pad;

    always_comb begin
        base_pad = '0;
        mask_pad = '0;
        tgt_pad  = '0;
        for (int i = 0; i < P_NREGIONS; i++) begin
            base_pad[i*MAX_AW +: MAX_AW] = MAX_AW'(P_REGION_BASE[i*P_ADDRWIDTH +: P_ADDRWIDTH]);
            mask_pad[i*MAX_AW +: MAX_AW] = MAX_AW'(P_REGION_MASK[i*P_ADDRWIDTH +: P_ADDRWIDTH]);
            tgt_pad[i*MAX_AW +: MAX_AW]  = MAX_AW'(P_REGION_TGT[i*P_ADDRWIDTH +: P_ADDRWIDTH]);
        end
    end

    decode_t aw_map, ar_map;
    logic    aw_fwd, ar_fwd;

    assign aw_map = region_decode(MAX_AW'(axis_awaddr), base_pad, mask_pad, tgt_pad, P_NREGIONS);
    assign ar_map = region_decode(MAX_AW'(axis_araddr), base_pad, mask_pad, tgt_pad, P_NREGIONS);
    assign aw_fwd = aw_map.hit || !P_DECERR;
    assign ar_fwd = ar_map.hit || !P_DECERR;

    // ---------------- write side ----------------
    wstate_e                  wst_q, wst_d;
    logic [P_AXI_IDWIDTH-1:0] awid_q, awid_d;
    logic [CW-1:0]            wout_q, wout_d;
    logic                     aw_s_valid, aw_s_ready, aw_slot;
    logic [AX_W-1:0]          aw_s_data, aw_m_data;

    assign aw_slot      = (wst_q == W_IDLE) && (wout_q < CW'(P_MAXOUT));
    // Misses wait until nothing forwarded is pending so same-ID order holds.
    assign axis_awready = aw_slot && (aw_fwd ? aw_s_ready : (wout_q == '0 && !axim_awvalid));
    assign aw_s_valid   = axis_awvalid && aw_slot && aw_fwd;
    assign aw_s_data    = {aw_map.addr[P_ADDRWIDTH-1:0], axis_awlen, axis_awsize, axis_awburst,
                           axis_awid, axis_awlock, axis_awcache, axis_awprot, axis_awuser};

    axi_remap_slice #(.P_WIDTH(AX_W)) u_aw_slice (
        .clk     (clk),
        .rst     (rst),
        .s_valid (aw_s_valid),
        .s_data  (aw_s_data),
        .s_ready (aw_s_ready),
        .m_valid (axim_awvalid),
        .m_data  (aw_m_data),
        .m_ready (axim_awready)
    );

    assign {axim_awaddr, axim_awlen, axim_awsize, axim_awburst, axim_awid,
            axim_awlock, axim_awcache, axim_awprot, axim_awuser} = aw_m_data;

    assign axim_wdata  = axis_wdata;
    assign axim_wstrb  = axis_wstrb;
    assign axim_wlast  = axis_wlast;
    assign axim_wuser  = axis_wuser;
    assign axim_wvalid = (wst_q == W_FWD) && axis_wvalid;
    assign axis_wready = (wst_q == W_FWD) ? axim_wready : (wst_q == W_SINK);

    assign axis_bvalid = (wst_q == W_RESP) ? 1'b1        : axim_bvalid;
    assign axis_bid    = (wst_q == W_RESP) ? awid_q      : axim_bid;
    assign axis_bresp  = (wst_q == W_RESP) ? RESP_DECERR : axim_bresp;
    assign axis_buser  = (wst_q == W_RESP) ? '0          : axim_buser;
    assign axim_bready = (wst_q != W_RESP) && axis_bready;

    always_comb begin
        wst_d  = wst_q;
        awid_d = awid_q;
        case (wst_q)
            W_IDLE: if (axis_awvalid && axis_awready) begin
                if (aw_fwd) begin
                    wst_d = W_FWD;
                end else begin
                    wst_d  = W_SINK;
                    awid_d = axis_awid;
                end
            end
            W_FWD:   if (axim_wvalid && axim_wready && axis_wlast) wst_d = W_IDLE;
            W_SINK:  if (axis_wvalid && axis_wlast) wst_d = W_RESP;
            W_RESP:  if (axis_bready) wst_d = W_IDLE;
            default: wst_d = W_IDLE;
        endcase
    end

    always_comb begin
        wout_d = wout_q;
        if ((axim_awvalid && axim_awready) && !(axim_bvalid && axim_bready)) begin
            wout_d = wout_q + CW'(1);
        end else if (!(axim_awvalid && axim_awready) && (axim_bvalid && axim_bready)) begin
            wout_d = wout_q - CW'(1);
        end
    end

    // ---------------- read side ----------------
    rstate_e                  rst_q, rst_d;
    logic [P_AXI_IDWIDTH-1:0] arid_q, arid_d;
    logic [7:0]               rcnt_q, rcnt_d;
    logic [CW-1:0]            rout_q, rout_d;
    logic                     ar_s_valid, ar_s_ready, ar_slot;
    logic [AX_W-1:0]          ar_s_data, ar_m_data;

    assign ar_slot      = (rst_q == R_IDLE) && (rout_q < CW'(P_MAXOUT));
    assign axis_arready = ar_slot && (ar_fwd ? ar_s_ready : (rout_q == '0 && !axim_arvalid));
    assign ar_s_valid   = axis_arvalid && ar_slot && ar_fwd;
    assign ar_s_data    = {ar_map.addr[P_ADDRWIDTH-1:0], axis_arlen, axis_arsize, axis_arburst,
                           axis_arid, axis_arlock, axis_arcache, axis_arprot, axis_aruser};

    axi_remap_slice #(.P_WIDTH(AX_W)) u_ar_slice (
        .clk     (clk),
        .rst     (rst),
        .s_valid (ar_s_valid),
        .s_data  (ar_s_data),
        .s_ready (ar_s_ready),
        .m_valid (axim_arvalid),
        .m_data  (ar_m_data),
        .m_ready (axim_arready)
    );

    assign {axim_araddr, axim_arlen, axim_arsize, axim_arburst, axim_arid,
            axim_arlock, axim_arcache, axim_arprot, axim_aruser} = ar_m_data;

    assign axis_rvalid = (rst_q == R_ERR) ? 1'b1             : axim_rvalid;
    assign axis_rdata  = (rst_q == R_ERR) ? '0               : axim_rdata;
    assign axis_rresp  = (rst_q == R_ERR) ? RESP_DECERR      : axim_rresp;
    assign axis_rid    = (rst_q == R_ERR) ? arid_q           : axim_rid;
    assign axis_rlast  = (rst_q == R_ERR) ? (rcnt_q == 8'd0) : axim_rlast;
    assign axis_ruser  = (rst_q == R_ERR) ? '0               : axim_ruser;
    assign axim_rready = (rst_q == R_IDLE) && axis_rready;

    always_comb begin
        rst_d  = rst_q;
        arid_d = arid_q;
        rcnt_d = rcnt_q;
        case (rst_q)
            R_IDLE: if (axis_arvalid && axis_arready && !ar_fwd) begin
                rst_d  = R_ERR;
                arid_d = axis_arid;
                rcnt_d = axis_arlen;
            end
            R_ERR: if (axis_rready) begin
                if (rcnt_q == 8'd0) rst_d = R_IDLE;
                else                rcnt_d = rcnt_q - 8'd1;
            end
            default: rst_d = R_IDLE;
        endcase
    end

    always_comb begin
        rout_d = rout_q;
        if ((axim_arvalid && axim_arready) && !(axim_rvalid && axim_rready && axim_rlast)) begin
            rout_d = rout_q + CW'(1);
        end else if (!(axim_arvalid && axim_arready) && (axim_rvalid && axim_rready && axim_rlast)) begin
            rout_d = rout_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wst_q  <= W_IDLE;
            awid_q <= '0;
            wout_q <= '0;
            rst_q  <= R_IDLE;
            arid_q <= '0;
            rcnt_q <= '0;
            rout_q <= '0;
        end else begin
            wst_q  <= wst_d;
            awid_q <= awid_d;
            wout_q <= wout_d;
            rst_q  <= rst_d;
            arid_q <= arid_d;
            rcnt_q <= rcnt_d;
            rout_q <= rout_d;
        end
    end

    assign dbg_wst = wst_q;
    assign dbg_rst = rst_q;

endmodule

// File: tb/tb_axi_remap_regions.sv
// Bench for axi_remap_regions: directed scenarios plus a randomized mix of
// hit/miss reads and writes, checked against a behavioural address map.
module tb_axi_remap_regions;
    import axi_remap_pkg::*;

    localparam int IDW = 5;
    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int UW  = 1;
    localparam int NR  = 4;
    localparam logic [NR*AW-1:0] BASE = {32'h4000_0000, 32'h2000_0000, 32'h1000_0000, 32'h2000_0000};
    localparam logic [NR*AW-1:0] MASK = {32'hC000_0000, 32'hF000_0000, 32'hF000_0000, 32'hFF00_0000};
    localparam logic [NR*AW-1:0] TGT  = {32'h8000_0000, 32'h5000_0000, 32'h0000_0000, 32'h7700_0000};

    // Reference map, region 0 first
    logic [31:0] m_base [4] = '{32'h2000_0000, 32'h1000_0000, 32'h2000_0000, 32'h4000_0000};
    logic [31:0] m_mask [4] = '{32'hFF00_0000, 32'hF000_0000, 32'hF000_0000, 32'hC000_0000};
    logic [31:0] m_tgt  [4] = '{32'h7700_0000, 32'h0000_0000, 32'h5000_0000, 32'h8000_0000};

    logic clk, rst;
    logic [AW-1:0] axis_awaddr, axis_araddr, axim_awaddr, axim_araddr;
    logic [7:0] axis_awlen, axis_arlen, axim_awlen, axim_arlen;
    logic [2:0] axis_awsize, axis_arsize, axim_awsize, axim_arsize;
    logic [1:0] axis_awburst, axis_arburst, axim_awburst, axim_arburst;
    logic [IDW-1:0] axis_awid, axis_arid, axim_awid, axim_arid;
    logic axis_awlock, axis_arlock, axim_awlock, axim_arlock;
    logic [3:0] axis_awcache, axis_arcache, axim_awcache, axim_arcache;
    logic [2:0] axis_awprot, axis_arprot, axim_awprot, axim_arprot;
    logic [UW-1:0] axis_awuser, axis_aruser, axim_awuser, axim_aruser;
    logic axis_awvalid, axis_awready, axis_arvalid, axis_arready;
    logic axim_awvalid, axim_awready, axim_arvalid, axim_arready;
    logic [DW-1:0] axis_wdata, axim_wdata, axis_rdata, axim_rdata;
    logic [DW/8-1:0] axis_wstrb, axim_wstrb;
    logic axis_wlast, axim_wlast, axis_wvalid, axis_wready, axim_wvalid, axim_wready;
    logic [UW-1:0] axis_wuser, axim_wuser, axis_buser, axim_buser, axis_ruser, axim_ruser;
    logic [IDW-1:0] axis_bid, axim_bid, axis_rid, axim_rid;
    logic [1:0] axis_bresp, axim_bresp, axis_rresp, axim_rresp;
    logic axis_bvalid, axis_bready, axim_bvalid, axim_bready;
    logic axis_rlast, axim_rlast, axis_rvalid, axis_rready, axim_rvalid, axim_rready;
    wstate_e dbg_wst;
    rstate_e dbg_rst;

    logic [DW-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    axi_remap_regions #(
        .P_AXI_IDWIDTH(IDW), .P_ADDRWIDTH(AW), .P_DATAWIDTH(DW), .P_USERWIDTH(UW),
        .P_NREGIONS(NR), .P_REGION_BASE(BASE), .P_REGION_MASK(MASK), .P_REGION_TGT(TGT),
        .P_DECERR(1'b1), .P_MAXOUT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .axis_awaddr(axis_awaddr), .axis_awlen(axis_awlen), .axis_awsize(axis_awsize),
        .axis_awburst(axis_awburst), .axis_awid(axis_awid), .axis_awlock(axis_awlock),
        .axis_awcache(axis_awcache), .axis_awprot(axis_awprot), .axis_awuser(axis_awuser),
        .axis_awvalid(axis_awvalid), .axis_awready(axis_awready),
        .axis_wdata(axis_wdata), .axis_wstrb(axis_wstrb), .axis_wlast(axis_wlast),
        .axis_wuser(axis_wuser), .axis_wvalid(axis_wvalid), .axis_wready(axis_wready),
        .axis_bid(axis_bid), .axis_bresp(axis_bresp), .axis_buser(axis_buser),
        .axis_bvalid(axis_bvalid), .axis_bready(axis_bready),
        .axis_araddr(axis_araddr), .axis_arlen(axis_arlen), .axis_arsize(axis_arsize),
        .axis_arburst(axis_arburst), .axis_arid(axis_arid), .axis_arlock(axis_arlock),
        .axis_arcache(axis_arcache), .axis_arprot(axis_arprot), .axis_aruser(axis_aruser),
        .axis_arvalid(axis_arvalid), .axis_arready(axis_arready),
        .axis_rid(axis_rid), .axis_rdata(axis_rdata), .axis_rresp(axis_rresp),
        .axis_rlast(axis_rlast), .axis_ruser(axis_ruser), .axis_rvalid(axis_rvalid),
        .axis_rready(axis_rready),
        .axim_awaddr(axim_awaddr), .axim_awlen(axim_awlen), .axim_awsize(axim_awsize),
        .axim_awburst(axim_awburst), .axim_awid(axim_awid), .axim_awlock(axim_awlock),
        .axim_awcache(axim_awcache), .axim_awprot(axim_awprot), .axim_awuser(axim_awuser),
        .axim_awvalid(axim_awvalid), .axim_awready(axim_awready),
        .axim_wdata(axim_wdata), .axim_wstrb(axim_wstrb), .axim_wlast(axim_wlast),
        .axim_wuser(axim_wuser), .axim_wvalid(axim_wvalid), .axim_wready(axim_wready),
        .axim_bid(axim_bid), .axim_bresp(axim_bresp), .axim_buser(axim_buser),
        .axim_bvalid(axim_bvalid), .axim_bready(axim_bready),
        .axim_araddr(axim_araddr), .axim_arlen(axim_arlen), .axim_arsize(axim_arsize),
        .axim_arburst(axim_arburst), .axim_arid(axim_arid), .axim_arlock(axim_arlock),
        .axim_arcache(axim_arcache), .axim_arprot(axim_arprot), .axim_aruser(axim_aruser),
        .axim_arvalid(axim_arvalid), .axim_arready(axim_arready),
        .axim_rid(axim_rid), .axim_rdata(axim_rdata), .axim_rresp(axim_rresp),
        .axim_rlast(axim_rlast), .axim_ruser(axim_ruser), .axim_rvalid(axim_rvalid),
        .axim_rready(axim_rready),
        .dbg_wst(dbg_wst), .dbg_rst(dbg_rst)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void ref_map(input logic [31:0] a, output bit fwd, output logic [31:0] xa);
        fwd = 1'b0;
        xa  = a;
        for (int i = 0; i < 4; i++) begin
            if (!fwd && ((a ^ m_base[i]) & m_mask[i]) == 32'h0) begin
                fwd = 1'b1;
                xa  = (a & ~m_mask[i]) | (m_tgt[i] & m_mask[i]);
            end
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_aw(input logic [31:0] a, input logic [7:0] len, input logic [IDW-1:0] id,
                           output bit fwd);
        logic [31:0] xa;
        logic [3:0]  cache;
        int          n;
        ref_map(a, fwd, xa);
        cache = 4'($urandom_range(15, 0));
        axis_awaddr = a; axis_awlen = len; axis_awid = id; axis_awcache = cache;
        axis_awsize = 3'd3; axis_awburst = 2'b01; axis_awprot = 3'($urandom_range(7, 0));
        axis_awlock = 1'b0; axis_awuser = UW'($urandom_range(1, 0));
        axis_awvalid = 1'b1;
        #1;
        n = 0;
        while (!axis_awready && n < 200) begin tick(); n++; end
        check("aw_accept_timeout", 64'(n < 200), 64'd1);
        tick();
        axis_awvalid = 1'b0;
        if (fwd) begin
            check("aw_fwd_valid", axim_awvalid, 1);
            check("aw_fwd_addr", axim_awaddr, xa);
            check("aw_fwd_len", axim_awlen, len);
            check("aw_fwd_id", axim_awid, id);
            check("aw_fwd_cache", axim_awcache, cache);
        end else begin
            check("aw_miss_no_fwd", axim_awvalid, 0);
        end
    endtask

    task automatic send_w(input logic [7:0] len, input bit fwd);
        logic [DW-1:0] d;
        for (int b = 0; b <= int'(len); b++) begin
            d = {$urandom, $urandom};
            axis_wdata = d; axis_wstrb = 8'($urandom); axis_wlast = (b == int'(len));
            axis_wuser = UW'($urandom_range(1, 0)); axis_wvalid = 1'b1; axim_wready = 1'b1;
            #1;
            if (fwd) begin
                exp_q.push_back(d);
                check("w_fwd_valid", axim_wvalid, 1);
                check("w_fwd_data", axim_wdata, exp_q.pop_front());
                check("w_fwd_last", axim_wlast, 64'(b == int'(len)));
            end else begin
                check("w_sink_no_fwd", axim_wvalid, 0);
            end
            check("w_ready", axis_wready, 1);
            tick();
        end
        axis_wvalid = 1'b0;
        axis_wlast  = 1'b0;
    endtask

    task automatic recv_b(input logic [IDW-1:0] id, input bit fwd);
        logic [1:0] r;
        if (fwd) begin
            r = 2'($urandom_range(2, 0));
            axim_bid = id; axim_bresp = r; axim_buser = 1'b1; axim_bvalid = 1'b1;
            axis_bready = 1'b1;
            #1;
            check("b_fwd_valid", axis_bvalid, 1);
            check("b_fwd_id", axis_bid, id);
            check("b_fwd_resp", axis_bresp, r);
            check("b_fwd_bready", axim_bready, 1);
            tick();
            axim_bvalid = 1'b0;
            axis_bready = 1'b0;
        end else begin
            if ($urandom_range(1, 0) == 1) begin
                axis_bready = 1'b0;
                tick();
            end
            axis_bready = 1'b1;
            #1;
            check("b_err_valid", axis_bvalid, 1);
            check("b_err_id", axis_bid, id);
            check("b_err_resp", axis_bresp, 2'b11);
            check("b_err_user", axis_buser, 0);
            check("b_err_no_bready", axim_bready, 0);
            tick();
            axis_bready = 1'b0;
        end
        #1;
        check("b_done_idle", axis_bvalid, 0);
    endtask

    task automatic send_ar(input logic [31:0] a, input logic [7:0] len, input logic [IDW-1:0] id,
                           output bit fwd);
        logic [31:0] xa;
        int          n;
        ref_map(a, fwd, xa);
        axis_araddr = a; axis_arlen = len; axis_arid = id; axis_arcache = 4'h3;
        axis_arsize = 3'd3; axis_arburst = 2'b01; axis_arprot = 3'd0;
        axis_arlock = 1'b0; axis_aruser = 1'b0;
        axis_arvalid = 1'b1;
        #1;
        n = 0;
        while (!axis_arready && n < 200) begin tick(); n++; end
        check("ar_accept_timeout", 64'(n < 200), 64'd1);
        tick();
        axis_arvalid = 1'b0;
        if (fwd) begin
            check("ar_fwd_valid", axim_arvalid, 1);
            check("ar_fwd_addr", axim_araddr, xa);
            check("ar_fwd_len", axim_arlen, len);
            check("ar_fwd_id", axim_arid, id);
        end else begin
            check("ar_miss_no_fwd", axim_arvalid, 0);
        end
    endtask

    task automatic recv_r(input logic [IDW-1:0] id, input logic [7:0] len, input bit fwd);
        logic [DW-1:0] d;
        logic [1:0]    r;
        for (int b = 0; b <= int'(len); b++) begin
            if (fwd) begin
                d = {$urandom, $urandom};
                r = 2'($urandom_range(2, 0));
                axim_rvalid = 1'b1; axim_rdata = d; axim_rid = id; axim_rresp = r;
                axim_rlast = (b == int'(len)); axim_ruser = 1'b1; axis_rready = 1'b1;
                #1;
                check("r_fwd_valid", axis_rvalid, 1);
                check("r_fwd_data", axis_rdata, d);
                check("r_fwd_resp", axis_rresp, r);
                check("r_fwd_id", axis_rid, id);
                check("r_fwd_last", axis_rlast, 64'(b == int'(len)));
                check("r_fwd_rready", axim_rready, 1);
            end else begin
                if ($urandom_range(3, 0) == 0) begin
                    axis_rready = 1'b0;
                    tick();
                    check("r_err_hold", axis_rvalid, 1);
                end
                axis_rready = 1'b1;
                #1;
                check("r_err_valid", axis_rvalid, 1);
                check("r_err_data", axis_rdata, 0);
                check("r_err_resp", axis_rresp, 2'b11);
                check("r_err_id", axis_rid, id);
                check("r_err_last", axis_rlast, 64'(b == int'(len)));
                check("r_err_no_rready", axim_rready, 0);
            end
            tick();
        end
        axim_rvalid = 1'b0;
        axim_rlast  = 1'b0;
        axis_rready = 1'b0;
        #1;
        check("r_done_idle", axis_rvalid, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit          fwd, fa, fb;
        logic [31:0] a;
        logic [7:0]  len;
        logic [4:0]  id;

        rst = 1'b1;
        axis_awaddr = '0; axis_awlen = '0; axis_awsize = '0; axis_awburst = '0; axis_awid = '0;
        axis_awlock = 1'b0; axis_awcache = '0; axis_awprot = '0; axis_awuser = '0; axis_awvalid = 1'b0;
        axis_wdata = '0; axis_wstrb = '0; axis_wlast = 1'b0; axis_wuser = '0; axis_wvalid = 1'b0;
        axis_bready = 1'b0;
        axis_araddr = '0; axis_arlen = '0; axis_arsize = '0; axis_arburst = '0; axis_arid = '0;
        axis_arlock = 1'b0; axis_arcache = '0; axis_arprot = '0; axis_aruser = '0; axis_arvalid = 1'b0;
        axis_rready = 1'b0;
        axim_awready = 1'b1; axim_wready = 1'b1; axim_arready = 1'b1;
        axim_bid = '0; axim_bresp = '0; axim_buser = '0; axim_bvalid = 1'b0;
        axim_rid = '0; axim_rdata = '0; axim_rresp = '0; axim_rlast = 1'b0; axim_ruser = '0;
        axim_rvalid = 1'b0;

        repeat (3) tick();
        check("rst_awvalid", axim_awvalid, 0);
        check("rst_arvalid", axim_arvalid, 0);
        check("rst_bvalid", axis_bvalid, 0);
        check("rst_rvalid", axis_rvalid, 0);
        check("rst_wst", dbg_wst, W_IDLE);
        check("rst_rst", dbg_rst, R_IDLE);
        rst = 1'b0;
        tick();
        check("idle_awready", axis_awready, 1);
        check("idle_arready", axis_arready, 1);

        // Region 1 read with pass-through data
        send_ar(32'h1234_5678, 8'd0, 5'd1, fwd);
        check("plan_araddr", axim_araddr, 32'h0234_5678);
        recv_r(5'd1, 8'd0, fwd);

        // Miss write, four beats
        send_aw(32'h3000_0100, 8'd3, 5'd12, fwd);
        check("miss_wr_class", 64'(fwd), 0);
        send_w(8'd3, fwd);
        recv_b(5'd12, fwd);

        // Miss read, three beats
        send_ar(32'h9000_0000, 8'd2, 5'd5, fwd);
        recv_r(5'd5, 8'd2, fwd);

        // Regions 0 and 2 overlap; region 0 translation wins
        send_aw(32'h2034_5678, 8'd1, 5'd2, fwd);
        check("overlap_awaddr", axim_awaddr, 32'h7734_5678);
        send_w(8'd1, fwd);
        recv_b(5'd2, fwd);

        // Two forwarded reads outstanding block a miss until both retire
        send_ar(32'h1000_0010, 8'd0, 5'd3, fa);
        send_ar(32'h5000_0020, 8'd0, 5'd4, fb);
        axis_araddr = 32'hF000_0000; axis_arlen = 8'd1; axis_arid = 5'd9; axis_arvalid = 1'b1;
        tick();
        check("ord_hold0", axis_arready, 0);
        tick();
        check("ord_hold1", axis_arready, 0);
        recv_r(5'd3, 8'd0, fa);
        check("ord_hold2", axis_arready, 0);
        recv_r(5'd4, 8'd0, fb);
        check("ord_release", axis_arready, 1);
        tick();
        axis_arvalid = 1'b0;
        check("ord_miss_no_fwd", axim_arvalid, 0);
        recv_r(5'd9, 8'd1, 1'b0);

        // Reset during the second beat of a sunk write
        send_aw(32'h3000_0000, 8'd3, 5'd9, fwd);
        axis_wvalid = 1'b1; axis_wlast = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("midrst_wst", dbg_wst, W_IDLE);
        check("midrst_wready", axis_wready, 0);
        axis_wvalid = 1'b0;
        tick();
        check("midrst_awvalid", axim_awvalid, 0);
        check("midrst_wvalid", axim_wvalid, 0);
        check("midrst_bvalid", axis_bvalid, 0);
        check("midrst_rvalid", axis_rvalid, 0);
        rst = 1'b0;
        tick();
        send_aw(32'h1000_0040, 8'd1, 5'd3, fwd);
        send_w(8'd1, fwd);
        recv_b(5'd3, fwd);

        // Randomized mix
        for (int t = 0; t < 30; t++) begin
            a = $urandom;
            if ($urandom_range(3, 0) == 0) a[31:24] = 8'h20;
            len = 8'($urandom_range(7, 0));
            id  = 5'($urandom_range(31, 0));
            if ($urandom_range(1, 0) == 1) begin
                send_aw(a, len, id, fwd);
                send_w(len, fwd);
                recv_b(id, fwd);
            end else begin
                send_ar(a, len, id, fwd);
                recv_r(id, len, fwd);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
